// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive engine: FSM states,
// FIFO entry layout, data-bit decode and the 3-sample majority vote.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PARITY  = 3'd3,
        ST_STOP1   = 3'd4,
        ST_STOP2   = 3'd5,
        ST_BRKWAIT = 3'd6
    } rx_state_e;

    localparam int ENT_W    = 11;
    localparam int DATA_LSB = 0;
    localparam int DATA_MSB = 7;
    localparam int PERR_POS = 8;
    localparam int FERR_POS = 9;
    localparam int BRK_POS  = 10;

    function automatic logic [3:0] bit_count(input logic [1:0] bits);
        return 4'd5 + {2'b00, bits};
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_sync_fifo.sv
// First-word-fall-through FIFO for received characters with their error flags.
// The head is presented straight from storage and reads as zero while empty.
module rx_sync_fifo
    import uart_rx_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [ENT_W-1:0] wdata,
    input  logic             rd,
    output logic [ENT_W-1:0] rdata,
    output logic             ne,
    output logic [CNT_W-1:0] count,
    output logic             ovf_evt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [ENT_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wptr_r;
    logic [PTR_W-1:0] rptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nx_s;
    logic             full_r;
    logic             ne_r;
    logic             do_rd_s;
    logic             do_wr_s;

    // Qualify requests, derive next occupancy and present the head entry
    always_comb begin
        do_rd_s = rd & ne_r;
        do_wr_s = wr & (~full_r | do_rd_s);
        ovf_evt = wr & full_r & ~do_rd_s;
        case ({do_wr_s, do_rd_s})
            2'b10:   count_nx_s = count_r + CNT_W'(1);
            2'b01:   count_nx_s = count_r - CNT_W'(1);
            default: count_nx_s = count_r;
        endcase
        if (ne_r) begin
            rdata = mem_r[rptr_r];
        end else begin
            rdata = '0;
        end
    end

    // Pointers and occupancy flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
            full_r  <= 1'b0;
            ne_r    <= 1'b0;
        end else begin
            if (do_wr_s) wptr_r <= wptr_r + PTR_W'(1);
            if (do_rd_s) rptr_r <= rptr_r + PTR_W'(1);
            count_r <= count_nx_s;
            full_r  <= (count_nx_s == DEPTH_C);
            ne_r    <= (count_nx_s != '0);
        end
    end

    // Entry storage; contents are never visible while empty, so no reset
    always_ff @(posedge clk) begin
        if (do_wr_s) mem_r[wptr_r] <= wdata;
    end

    assign ne    = ne_r;
    assign count = count_r;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive engine: line synchroniser, oversample tick generator and frame
// FSM with majority voting, feeding a FWFT FIFO of characters plus error flags.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int DIV_W = 19,
    parameter int OVS   = 16,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_rx,
    input  logic [DIV_W-1:0] i_rate,
    input  logic [1:0]       i_bits,
    input  logic             i_pen,
    input  logic             i_ohel,
    input  logic             i_stop2,
    input  logic             i_read,
    input  logic             i_clr_ovf,
    output logic             o_rxrdy,
    output logic [7:0]       o_rx_dout,
    output logic             o_perr,
    output logic             o_ferr,
    output logic             o_brk,
    output logic             o_ovf,
    output logic [CNT_W-1:0] o_count
);

    localparam int S_W = $clog2(OVS);
    localparam logic [S_W-1:0] S_V0   = S_W'(OVS / 2 - 1);
    localparam logic [S_W-1:0] S_V1   = S_W'(OVS / 2);
    localparam logic [S_W-1:0] S_V2   = S_W'(OVS / 2 + 1);
    localparam logic [S_W-1:0] S_LAST = S_W'(OVS - 1);

    logic             rx_meta_r, rx_sync_r;
    logic [DIV_W-1:0] tick_cnt_r;
    logic             tick_s;
    rx_state_e        state_r, state_nx_s;
    logic [S_W-1:0]   s_r;
    logic             v0_r, v1_r, maj_s, vote_s, last_s, start_s, data_last_s;
    logic [2:0]       bit_idx_r;
    logic [3:0]       nbits_r;
    logic             pen_r, ohel_r, stop2_r;
    logic [7:0]       shift_r;
    logic             par_r, perr_r, ferr_r, zero_r;
    logic             done_s, brk_s;
    logic [ENT_W-1:0] entry_s, wdata_r, head_s;
    logic             wr_r, ovf_r, ovf_evt_s;

    // Two-flop synchroniser, idle-high preset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= i_rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Oversample tick generator; >= recovers if i_rate shrinks below the count
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tick_cnt_r <= '0;
        end else if (tick_s) begin
            tick_cnt_r <= '0;
        end else begin
            tick_cnt_r <= tick_cnt_r + DIV_W'(1);
        end
    end

    // Sample-point strobes and the majority vote of the three mid-bit samples
    always_comb begin
        tick_s      = (tick_cnt_r >= i_rate);
        vote_s      = tick_s & (s_r == S_V2);
        last_s      = tick_s & (s_r == S_LAST);
        start_s     = (state_r == ST_IDLE) & tick_s & ~rx_sync_r;
        maj_s       = majority3(v0_r, v1_r, rx_sync_r);
        data_last_s = ({1'b0, bit_idx_r} == (nbits_r - 4'd1));
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE:    if (start_s) state_nx_s = ST_START; else state_nx_s = state_r;
            ST_START: begin
                if (vote_s && maj_s)  state_nx_s = ST_IDLE;
                else if (last_s)      state_nx_s = ST_DATA;
                else                  state_nx_s = state_r;
            end
            ST_DATA: begin
                if (last_s && data_last_s) state_nx_s = pen_r ? ST_PARITY : ST_STOP1;
                else                       state_nx_s = state_r;
            end
            ST_PARITY:  if (last_s) state_nx_s = ST_STOP1; else state_nx_s = state_r;
            ST_STOP1: begin
                if (vote_s && !stop2_r)      state_nx_s = brk_s ? ST_BRKWAIT : ST_IDLE;
                else if (last_s && stop2_r)  state_nx_s = ST_STOP2;
                else                         state_nx_s = state_r;
            end
            ST_STOP2: begin
                if (vote_s) state_nx_s = brk_s ? ST_BRKWAIT : ST_IDLE;
                else        state_nx_s = state_r;
            end
            ST_BRKWAIT: if (rx_sync_r) state_nx_s = ST_IDLE; else state_nx_s = state_r;
            default:    state_nx_s = ST_IDLE;
        endcase
    end

    // FSM outputs: frame completion strobe and the entry to be queued
    always_comb begin
        done_s  = vote_s & (((state_r == ST_STOP1) & ~stop2_r) | (state_r == ST_STOP2));
        brk_s   = zero_r & ~maj_s;
        entry_s = '0;
        if (brk_s) begin
            entry_s[BRK_POS]  = 1'b1;
            entry_s[FERR_POS] = 1'b1;
            entry_s[PERR_POS] = perr_r;
        end else begin
            entry_s[DATA_MSB:DATA_LSB] = shift_r;
            entry_s[FERR_POS]          = ferr_r | ~maj_s;
            entry_s[PERR_POS]          = perr_r;
        end
    end

    // Sample counter and early vote samples; cleared whenever the frame ends
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s_r  <= '0;
            v0_r <= 1'b1;
            v1_r <= 1'b1;
        end else begin
            if (state_r == ST_IDLE || state_r == ST_BRKWAIT || state_nx_s == ST_IDLE) begin
                s_r <= '0;
            end else if (tick_s) begin
                s_r <= (s_r == S_LAST) ? '0 : s_r + S_W'(1);
            end
            if (tick_s && s_r == S_V0) v0_r <= rx_sync_r;
            if (tick_s && s_r == S_V1) v1_r <= rx_sync_r;
        end
    end

    // Frame datapath: config latch, shift register and error accumulation
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            nbits_r   <= 4'd5;
            pen_r     <= 1'b0;
            ohel_r    <= 1'b0;
            stop2_r   <= 1'b0;
            shift_r   <= 8'h00;
            bit_idx_r <= 3'd0;
            par_r     <= 1'b0;
            perr_r    <= 1'b0;
            ferr_r    <= 1'b0;
            zero_r    <= 1'b1;
        end else if (start_s) begin
            nbits_r   <= bit_count(i_bits);
            pen_r     <= i_pen;
            ohel_r    <= i_ohel;
            stop2_r   <= i_stop2;
            shift_r   <= 8'h00;
            bit_idx_r <= 3'd0;
            par_r     <= 1'b0;
            perr_r    <= 1'b0;
            ferr_r    <= 1'b0;
            zero_r    <= 1'b1;
        end else begin
            if (vote_s) begin
                case (state_r)
                    ST_DATA: begin
                        shift_r[bit_idx_r] <= maj_s;
                        par_r              <= par_r ^ maj_s;
                        zero_r             <= zero_r & ~maj_s;
                    end
                    ST_PARITY: begin
                        perr_r <= ((par_r ^ maj_s) != ohel_r);
                        zero_r <= zero_r & ~maj_s;
                    end
                    ST_STOP1: begin
                        ferr_r <= ferr_r | ~maj_s;
                        zero_r <= zero_r & ~maj_s;
                    end
                    default: zero_r <= zero_r;
                endcase
            end
            if (last_s && state_r == ST_DATA) bit_idx_r <= bit_idx_r + 3'd1;
        end
    end

    // Registered FIFO write and sticky overflow (set wins over clear)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_r    <= 1'b0;
            wdata_r <= '0;
            ovf_r   <= 1'b0;
        end else begin
            wr_r    <= done_s;
            wdata_r <= entry_s;
            if (ovf_evt_s)      ovf_r <= 1'b1;
            else if (i_clr_ovf) ovf_r <= 1'b0;
        end
    end

    rx_sync_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .wr      (wr_r),
        .wdata   (wdata_r),
        .rd      (i_read),
        .rdata   (head_s),
        .ne      (o_rxrdy),
        .count   (o_count),
        .ovf_evt (ovf_evt_s)
    );

    assign o_rx_dout = head_s[DATA_MSB:DATA_LSB];
    assign o_perr    = head_s[PERR_POS];
    assign o_ferr    = head_s[FERR_POS];
    assign o_brk     = head_s[BRK_POS];
    assign o_ovf     = ovf_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: OVS=16, i_rate=6 (112 clocks per bit), DEPTH=4.
module tb_uart_rx_fifo;

    localparam int DIV_W    = 19;
    localparam int DEPTH    = 4;
    localparam int CNT_W    = 3;
    localparam int BIT_CLKS = 112;

    logic             i_clk = 1'b0;
    logic             i_rst_n;
    logic             i_rx;
    logic [DIV_W-1:0] i_rate;
    logic [1:0]       i_bits;
    logic             i_pen, i_ohel, i_stop2, i_read, i_clr_ovf;
    logic             o_rxrdy, o_perr, o_ferr, o_brk, o_ovf;
    logic [7:0]       o_rx_dout;
    logic [CNT_W-1:0] o_count;

    int n_assert = 0;
    int n_fail   = 0;

    uart_rx_fifo #(.DIV_W(DIV_W), .OVS(16), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rx(i_rx), .i_rate(i_rate),
        .i_bits(i_bits), .i_pen(i_pen), .i_ohel(i_ohel), .i_stop2(i_stop2),
        .i_read(i_read), .i_clr_ovf(i_clr_ovf), .o_rxrdy(o_rxrdy),
        .o_rx_dout(o_rx_dout), .o_perr(o_perr), .o_ferr(o_ferr), .o_brk(o_brk),
        .o_ovf(o_ovf), .o_count(o_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        i_rx = v;
        repeat (BIT_CLKS) @(negedge i_clk);
    endtask

    task automatic send_head(input logic [7:0] d, input int nb, input logic use_par, input logic pbit);
        send_bit(1'b0);
        for (int i = 0; i < nb; i++) send_bit(d[i]);
        if (use_par) send_bit(pbit);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input logic use_par,
                              input logic pbit, input int nstop, input logic stop2v);
        send_head(d, nb, use_par, pbit);
        send_bit(1'b1);
        if (nstop == 2) send_bit(stop2v);
        send_bit(1'b1);
        send_bit(1'b1);
    endtask

    task automatic pop();
        i_read = 1'b1;
        @(negedge i_clk);
        i_read = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic check_head(input string tag, input logic [7:0] d, input logic pe,
                              input logic fe, input logic bk);
        check({tag, "_data"}, o_rx_dout, d);
        check({tag, "_perr"}, o_perr, pe);
        check({tag, "_ferr"}, o_ferr, fe);
        check({tag, "_brk"},  o_brk, bk);
    endtask

    initial begin
        int got;
        i_rst_n = 1'b0; i_rx = 1'b1; i_rate = 19'd6; i_bits = 2'b11;
        i_pen = 1'b0; i_ohel = 1'b0; i_stop2 = 1'b0; i_read = 1'b0; i_clr_ovf = 1'b0;
        #23;
        check("rst_rxrdy", o_rxrdy, 1'b0);
        check("rst_count", o_count, 3'd0);
        check("rst_ovf", o_ovf, 1'b0);
        check_head("rst", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge i_clk); i_rst_n = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge i_clk);

        // 1: 8N1, 0xA5
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1);
        check("t1_rxrdy", o_rxrdy, 1'b1);
        check("t1_count", o_count, 3'd1);
        check_head("t1", 8'hA5, 1'b0, 1'b0, 1'b0);
        pop();
        check("t1_rxrdy_pop", o_rxrdy, 1'b0);
        check("t1_count_pop", o_count, 3'd0);

        // 2: 7 bits odd parity; 0x35 has four ones -> parity bit 1 is correct
        i_bits = 2'b10; i_pen = 1'b1; i_ohel = 1'b1;
        send_frame(8'h35, 7, 1'b1, 1'b1, 1, 1'b1);
        send_frame(8'h35, 7, 1'b1, 1'b0, 1, 1'b1);
        check("t2_count", o_count, 3'd2);
        check_head("t2_e1", 8'h35, 1'b0, 1'b0, 1'b0);
        pop();
        check_head("t2_e2", 8'h35, 1'b1, 1'b0, 1'b0);
        pop();
        check("t2_count_end", o_count, 3'd0);

        // 3: false start of 4 ticks, then a clean 8N1 frame
        i_bits = 2'b11; i_pen = 1'b0; i_ohel = 1'b0;
        i_rx = 1'b0;
        repeat (28) @(negedge i_clk);
        i_rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge i_clk);
        check("t3_nowrite", o_count, 3'd0);
        check("t3_idle", dut.state_r, 3'd0);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 1'b1);
        check("t3_count", o_count, 3'd1);
        check_head("t3", 8'h3C, 1'b0, 1'b0, 1'b0);
        pop();

        // 4: 8E2 with second stop bit low, then a 15-bit break
        i_pen = 1'b1; i_ohel = 1'b0; i_stop2 = 1'b1;
        send_frame(8'h55, 8, 1'b1, 1'b0, 2, 1'b0);
        check("t4_count_ferr", o_count, 3'd1);
        check_head("t4_ferr", 8'h55, 1'b0, 1'b1, 1'b0);
        pop();
        i_rx = 1'b0;
        repeat (15 * BIT_CLKS) @(negedge i_clk);
        check("t4_brk_count", o_count, 3'd1);
        check("t4_brk_data", o_rx_dout, 8'h00);
        check("t4_brk_flag", o_brk, 1'b1);
        check("t4_brk_ferr", o_ferr, 1'b1);
        i_rx = 1'b1;
        repeat (12 * BIT_CLKS) @(negedge i_clk);
        check("t4_brk_single", o_count, 3'd1);
        pop();
        check("t4_count_end", o_count, 3'd0);

        // 5: overflow with DEPTH=4
        i_pen = 1'b0; i_stop2 = 1'b0;
        for (int k = 1; k <= 5; k++) send_frame(8'(k), 8, 1'b0, 1'b0, 1, 1'b1);
        check("t5_count_full", o_count, 3'd4);
        check("t5_ovf", o_ovf, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            check("t5_pop_data", o_rx_dout, 32'(k));
            pop();
        end
        check("t5_count_empty", o_count, 3'd0);
        check("t5_ovf_sticky", o_ovf, 1'b1);
        i_clr_ovf = 1'b1; @(negedge i_clk); i_clr_ovf = 1'b0; @(negedge i_clk);
        check("t5_ovf_clr", o_ovf, 1'b0);
        send_frame(8'h11, 8, 1'b0, 1'b0, 1, 1'b1);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1, 1'b1);
        send_frame(8'h33, 8, 1'b0, 1'b0, 1, 1'b1);
        send_frame(8'h44, 8, 1'b0, 1'b0, 1, 1'b1);
        send_head(8'h55, 8, 1'b0, 1'b0);
        i_rx = 1'b1;
        got = 0;
        for (int k = 0; k < 400 && got == 0; k++) begin
            @(negedge i_clk);
            if (dut.wr_r) begin
                got = 1;
                i_read = 1'b1;
                @(negedge i_clk);
                i_read = 1'b0;
            end
        end
        check("t5_rw_sync", got, 1);
        repeat (2 * BIT_CLKS) @(negedge i_clk);
        check("t5_rw_count", o_count, 3'd4);
        check("t5_rw_ovf", o_ovf, 1'b0);
        check("t5_wrap_0", o_rx_dout, 8'h22); pop();
        check("t5_wrap_1", o_rx_dout, 8'h33); pop();
        check("t5_wrap_2", o_rx_dout, 8'h44); pop();
        check("t5_wrap_3", o_rx_dout, 8'h55); pop();
        check("t5_count_end", o_count, 3'd0);

        // 6: reset mid-DATA with two entries queued
        send_frame(8'h81, 8, 1'b0, 1'b0, 1, 1'b1);
        send_frame(8'h42, 8, 1'b0, 1'b0, 1, 1'b1);
        check("t6_pre_count", o_count, 3'd2);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        i_rst_n = 1'b0;
        #1;
        check("t6_rst_rxrdy", o_rxrdy, 1'b0);
        check("t6_rst_count", o_count, 3'd0);
        check("t6_rst_ovf", o_ovf, 1'b0);
        check_head("t6_rst", 8'h00, 1'b0, 1'b0, 1'b0);
        i_rx = 1'b1;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge i_clk);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1, 1'b1);
        check("t6_count", o_count, 3'd1);
        check_head("t6", 8'h5A, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised next-generation UART receive engine for the SOPC serial path. Oversamples the serial line with a programmable baud divisor and majority-votes each bit. Supports 5–8 data bits, optional odd/even parity, 1 or 2 stop bits, and break detection. Buffers received characters with per-character error flags in a first-word-fall-through FIFO, for the CPU-side register interface.

Parameters:
DIV_W, 19, width of baud divisor i_rate
OVS, 16, oversample ticks per bit (even, >=8)
DEPTH, 16, FIFO entries (power of 2, >=2)
CNT_W, $clog2(DEPTH+1), width of o_count

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_rx  in  1  serial line, asynchronous, idle high
i_rate  in  DIV_W  clocks per oversample tick minus 1
i_bits  in  2  data bits: 00=5, 01=6, 10=7, 11=8
i_pen  in  1  parity enable
i_ohel  in  1  parity sense: 1=odd, 0=even
i_stop2  in  1  check two stop bits
i_read  in  1  pop FIFO head (one-cycle pulse)
i_clr_ovf  in  1  clear sticky overflow
o_rxrdy  out  1  FIFO not empty
o_rx_dout  out  8  head data, unused upper bits zero
o_perr  out  1  head parity error
o_ferr  out  1  head framing error
o_brk  out  1  head break flag
o_ovf  out  1  sticky overflow
o_count  out  CNT_W  FIFO occupancy

Behaviour:
- Reset (asynchronous): all outputs 0, FIFO empty, state IDLE, synchroniser flops preset to 1, tick counter 0.
- i_rx passes through a 2-flop synchroniser; all logic uses the synchronised value.
- Tick generator:
  - Free-running counter 0..i_rate; one-clock tick when count==i_rate, then wraps to 0.
  - i_rate=0 gives a tick every clock.
- Per-bit sample counter s counts ticks 0..OVS-1. Bit value = majority of samples at s = OVS/2-1, OVS/2 and OVS/2+1.
- Configuration (i_bits, i_pen, i_ohel, i_stop2) is latched on start detection. Changes mid-frame have no effect until the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, BRKWAIT.
  - IDLE: on first tick with line low -> START, s=0.
  - START: at vote time, if majority is 1 -> IDLE (false start, nothing written). At s=OVS-1 -> DATA.
  - DATA: shift in LSB first. After the latched bit count -> PARITY if pen, else STOP1.
  - PARITY: sample parity bit. perr = (XOR of data bits ^ parity bit) != ohel.
  - STOP1: at vote time, ferr |= ~bit. If stop2 -> STOP2 at s=OVS-1; else complete the frame at vote time -> IDLE (mid-bit resync).
  - STOP2: same check as STOP1; complete the frame at vote time.
  - Break: all data bits, parity (if enabled) and stop bit(s) are 0 -> brk=1, ferr=1, data=0. Go to BRKWAIT instead of IDLE. BRKWAIT holds until the synchronised line is 1 -> IDLE. Exactly one entry is written per break.
- Frame completion writes {brk, ferr, perr, data[7:0]} to the FIFO in one clock.
- FIFO: first-word-fall-through. o_rx_dout and the flags show the head combinationally from storage.
  - i_read when empty is ignored.
  - Write when full and no read: entry discarded, o_ovf=1, existing entries untouched.
  - Read and write in the same cycle when full: both performed, no overflow, count unchanged.
  - Read and write in the same cycle when empty: write performed, read ignored.
  - Pointers wrap modulo DEPTH.
- o_ovf: set has priority over i_clr_ovf in the same cycle. Only i_clr_ovf or reset clears it.
- Latency: frame written 1 clock after the final stop vote tick. o_rxrdy and o_count update the following cycle.

Decomposition:
- Package uart_rx_pkg: FSM state enum, FIFO entry field positions (DATA 7:0, PERR 8, FERR 9, BRK 10), bit-count decode function (i_bits -> 5..8).
- Sub-module rx_sync_fifo: DEPTH x 11-bit FWFT FIFO with full/empty/count.
- Top level holds the synchroniser, tick generator and FSM.

Test Plan:
All scenarios use OVS=16, i_rate=6 (112 clocks/bit).
1. 8 bits, no parity, 1 stop; send 0xA5 -> o_rxrdy=1, o_rx_dout=0xA5, perr=ferr=brk=0, count=1; pulse i_read -> rxrdy=0, count=0.
2. 7 bits, odd parity; send 0x35 with correct parity, then 0x35 with parity inverted -> entry 1 has perr=0, entry 2 has perr=1, both data 0x35.
3. Line low for 4 ticks only, then high -> no write, FSM back in IDLE. A following frame 0x3C is received correctly.
4. 8 bits, parity on, i_stop2=1; second stop bit driven 0 -> ferr=1, brk=0. Line held low for 15 bit times -> exactly one entry with 0x00, brk=1, ferr=1; no further entries until the line goes high.
5. DEPTH=4; send 0x01..0x05 without reads -> count=4, o_ovf=1, pops return 0x01..0x04. Pulse i_clr_ovf -> ovf=0. Simultaneous read and write when full -> count stays 4, ovf stays 0.
6. Assert i_rst_n=0 mid-DATA with 2 entries queued -> all outputs 0, count=0. After release, 0x5A is received correctly.
